// File: rtl/openstrive_memctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : openstrive_memctrl_pkg
//  Purpose  : Shared types and constants for the on-chip SRAM initiator.
//             Holds the FSM state encoding, SRAM port widths and the default
//             error read-data pattern.
//  Revision : 1.0 - initial release
// ============================================================================
package openstrive_memctrl_pkg;

  localparam int unsigned RAM_ADDR_W = 22;
  localparam int unsigned DATA_W     = 32;

  localparam logic [DATA_W-1:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RWAIT = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/openstrive_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : openstrive_sat_counter
//  Purpose  : Saturating event counter. Increments by one on each cycle with
//             inc=1 and holds at all-ones.
//  Ports    : clk   - clock, rising edge
//             reset - asynchronous active-high reset, clears count to 0
//             inc   - increment request
//             count - current count value
//  Revision : 1.0 - initial release
// ============================================================================
module openstrive_sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/openstrive_soc_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : openstrive_soc_mem_ctrl
//  Purpose  : CPU native-interface initiator for the on-chip SRAM macro.
//             Range-checks each request, drives a single SRAM access and
//             returns a one-cycle ready pulse with read data / error flag.
//             Out-of-window accesses never touch the SRAM.
//  Ports    : clk, reset            - clock / async active-high reset
//             mem_valid/addr/wdata/wstrb  - CPU request (wstrb=0 means read)
//             mem_ready/rdata/err   - registered completion response
//             ram_ena/wen/addr/wdata - SRAM macro request (registered)
//             ram_rdata             - SRAM read data, one cycle after ram_ena
//             rd_count/wr_count/err_count - access statistics (optional)
//  Options  : OPENSTRIVE_MEMCTRL_STATS_EN adds saturating statistics counters.
//  Revision : 1.0 - initial release
// ============================================================================
module openstrive_soc_mem_ctrl
  import openstrive_memctrl_pkg::*;
#(
  parameter int unsigned       WORDS     = 128,
  parameter logic [31:0]       BASE_ADDR = 32'h0000_0000,
  parameter logic [DATA_W-1:0] ERR_DATA  = DEFAULT_ERR_DATA
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef OPENSTRIVE_MEMCTRL_STATS_EN
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count,
  output logic [7:0]            err_count,
`endif
  input  logic                  mem_valid,
  input  logic [31:0]           mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_err,
  output logic                  ram_ena,
  output logic [3:0]            ram_wen,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata
);

  // WORDS is at most 2^22, so the window size always fits in 32 bits.
  localparam logic [31:0] c_WIN_BYTES = 32'(4 * WORDS);

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic [31:0]           w_offset;
  logic                  w_in_range;
  logic [RAM_ADDR_W-1:0] w_word_idx;
  logic                  w_unused_lsb;

  // The lower bound is tested explicitly so an address below the window
  // cannot wrap the subtraction into a small in-range offset.
  assign w_offset     = mem_addr - BASE_ADDR;
  assign w_in_range   = (mem_addr >= BASE_ADDR) && (w_offset < c_WIN_BYTES);
  assign w_word_idx   = w_offset[RAM_ADDR_W+1:2];
  assign w_unused_lsb = ^w_offset[1:0];

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  state_e                state_q;
  logic [3:0]            wstrb_q;
  logic                  mem_ready_q;
  logic [DATA_W-1:0]     mem_rdata_q;
  logic                  mem_err_q;
  logic                  ram_ena_q;
  logic [3:0]            ram_wen_q;
  logic [RAM_ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0]     ram_wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wstrb_q     <= 4'h0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      mem_err_q   <= 1'b0;
      ram_ena_q   <= 1'b0;
      ram_wen_q   <= 4'h0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      // Ready is a single-cycle pulse; it is only raised on entry to ACK.
      mem_ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mem_valid) begin
            wstrb_q <= mem_wstrb;
            if (w_in_range) begin
              // Latched request is presented to the SRAM during ISSUE.
              ram_ena_q   <= 1'b1;
              ram_wen_q   <= mem_wstrb;
              ram_addr_q  <= w_word_idx;
              ram_wdata_q <= mem_wdata;
              state_q     <= ST_ISSUE;
            end else begin
              mem_rdata_q <= ERR_DATA;
              mem_err_q   <= 1'b1;
              mem_ready_q <= 1'b1;
              state_q     <= ST_ACK;
            end
          end
        end
        ST_ISSUE: begin
          ram_ena_q <= 1'b0;
          ram_wen_q <= 4'h0;
          if (wstrb_q != 4'h0) begin
            mem_rdata_q <= '0;
            mem_ready_q <= 1'b1;
            state_q     <= ST_ACK;
          end else begin
            state_q <= ST_RWAIT;
          end
        end
        ST_RWAIT: begin
          mem_rdata_q <= ram_rdata;
          mem_ready_q <= 1'b1;
          state_q     <= ST_ACK;
        end
        ST_ACK: begin
          mem_err_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_err   = mem_err_q;
  assign ram_ena   = ram_ena_q;
  assign ram_wen   = ram_wen_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

  // --------------------------------------------------------------------------
  // Optional statistics: classified in the ACK cycle (ready pulse).
  // --------------------------------------------------------------------------
`ifdef OPENSTRIVE_MEMCTRL_STATS_EN
  logic w_inc_rd;
  logic w_inc_wr;
  logic w_inc_err;

  assign w_inc_err = mem_ready_q & mem_err_q;
  assign w_inc_rd  = mem_ready_q & ~mem_err_q & (wstrb_q == 4'h0);
  assign w_inc_wr  = mem_ready_q & ~mem_err_q & (wstrb_q != 4'h0);

  openstrive_sat_counter #(.WIDTH(16)) u_rd_count (
    .clk   (clk),
    .reset (reset),
    .inc   (w_inc_rd),
    .count (rd_count)
  );

  openstrive_sat_counter #(.WIDTH(16)) u_wr_count (
    .clk   (clk),
    .reset (reset),
    .inc   (w_inc_wr),
    .count (wr_count)
  );

  openstrive_sat_counter #(.WIDTH(8)) u_err_count (
    .clk   (clk),
    .reset (reset),
    .inc   (w_inc_err),
    .count (err_count)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_openstrive_soc_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_openstrive_soc_mem_ctrl
//  Purpose  : Self-checking bench for openstrive_soc_mem_ctrl. Includes a
//             behavioural SRAM macro and a word-array reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_openstrive_soc_mem_ctrl;

  localparam int unsigned WORDS = 128;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [31:0] ERRD  = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        ram_ena;
  logic [3:0]  ram_wen;
  logic [21:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
`ifdef OPENSTRIVE_MEMCTRL_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
  logic [7:0]  err_count;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] ref_mem [WORDS];
  int          n_done = 0;
  int          n_rd = 0, n_wr = 0, n_err = 0;
  bit          do_init = 1'b0;

  // Ready-pulse monitor
  int ready_pulses = 0;
  int ready_double = 0;
  logic prev_ready = 1'b0;

  always #5 clk = ~clk;

  openstrive_soc_mem_ctrl #(
    .WORDS     (WORDS),
    .BASE_ADDR (BASE),
    .ERR_DATA  (ERRD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef OPENSTRIVE_MEMCTRL_STATS_EN
    .rd_count  (rd_count),
    .wr_count  (wr_count),
    .err_count (err_count),
`endif
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .mem_err   (mem_err),
    .ram_ena   (ram_ena),
    .ram_wen   (ram_wen),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Behavioural SRAM macro: one-cycle registered read, byte-enabled write.
  logic [31:0] sram [WORDS];
  always @(posedge clk) begin
    if (do_init) begin
      for (int i = 0; i < int'(WORDS); i++) sram[i] <= ref_mem[i];
    end else if (ram_ena) begin
      if (ram_wen == 4'h0) ram_rdata <= sram[int'(ram_addr) % WORDS];
      else
        for (int b = 0; b < 4; b++)
          if (ram_wen[b]) sram[int'(ram_addr) % WORDS][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
  end

  always @(negedge clk) begin
    if (mem_ready) ready_pulses++;
    if (mem_ready && prev_ready) ready_double++;
    prev_ready <= mem_ready;
  end

  function automatic bit in_win(input logic [31:0] a);
    longint la = longint'(a);
    return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * longint'(WORDS));
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // One request; extra = edges spent leaving a previous ACK before IDLE samples.
  task automatic req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     input int extra, input string tag, output logic [31:0] rd_o);
    int lat = 0, ena_n = 0, exp_lat, idx;
    bit got = 1'b0, inw;
    logic [31:0] exp_rd, wd_s = '0;
    logic [3:0]  wen_s = '0;
    logic [21:0] addr_s = '0;
    logic        err_s = 1'b0;
    rd_o = '0;
    inw  = in_win(a);
    idx  = inw ? int'((a - BASE) >> 2) : 0;
    exp_lat = extra + (!inw ? 1 : (ws != 4'h0) ? 2 : 3);
    exp_rd  = !inw ? ERRD : (ws != 4'h0) ? 32'h0 : ref_mem[idx];
    mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      // Payload may wander once the request is captured; it must be ignored.
      if (lat > extra) begin
        mem_addr = $urandom; mem_wdata = $urandom; mem_wstrb = 4'($urandom);
      end
      if (ram_ena) begin ena_n++; wen_s = ram_wen; addr_s = ram_addr; wd_s = ram_wdata; end
      if (mem_ready) begin got = 1'b1; rd_o = mem_rdata; err_s = mem_err; end
    end
    mem_valid = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no mem_ready within 20 edges", tag);
      return;
    end
    n_done++;
    checks++;
    if (lat !== exp_lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat); end
    checks++;
    if (rd_o !== exp_rd) begin errors++; $display("FAIL %s rdata: got %h want %h", tag, rd_o, exp_rd); end
    checks++;
    if (err_s !== !inw) begin errors++; $display("FAIL %s err: got %b want %b", tag, err_s, !inw); end
    checks++;
    if (ena_n !== (inw ? 1 : 0)) begin errors++; $display("FAIL %s ram_ena cycles: got %0d want %0d", tag, ena_n, inw ? 1 : 0); end
    if (inw) begin
      checks++;
      if (addr_s !== 22'(idx) || wen_s !== ws) begin
        errors++;
        $display("FAIL %s ram_addr/wen: got %0d/%h want %0d/%h", tag, addr_s, wen_s, idx, ws);
      end
      if (ws != 4'h0) begin
        checks++;
        if (wd_s !== wd) begin errors++; $display("FAIL %s ram_wdata: got %h want %h", tag, wd_s, wd); end
        for (int b = 0; b < 4; b++) if (ws[b]) ref_mem[idx][b*8 +: 8] = wd[b*8 +: 8];
        n_wr++;
      end else n_rd++;
    end else n_err++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < int'(WORDS); i++) ref_mem[i] = $urandom;
    reset = 1'b1; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    do_init = 1'b1;
    idle(2);
    do_init = 1'b0;
    checks++;
    if ({mem_ready, mem_err, mem_rdata, ram_ena, ram_wen, ram_addr, ram_wdata} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got rdy=%b err=%b rd=%h ena=%b wen=%h addr=%h wd=%h want all zero",
               mem_ready, mem_err, mem_rdata, ram_ena, ram_wen, ram_addr, ram_wdata);
    end
`ifdef OPENSTRIVE_MEMCTRL_STATS_EN
    checks++;
    if ({rd_count, wr_count, err_count} !== '0) begin
      errors++; $display("FAIL reset counters: got %0d/%0d/%0d want 0/0/0", rd_count, wr_count, err_count);
    end
`endif
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_plan_sequence();
    logic [31:0] rd;
    req(BASE + 32'd8, 32'hCAFE_F00D, 4'hF, 0, "wr_full", rd);  idle(1);
    req(BASE + 32'd8, 32'h0, 4'h0, 0, "rd_full", rd);          idle(1);
    checks++;
    if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL readback: got %h want %h", rd, 32'hCAFE_F00D); end
    req(BASE + 32'd8, 32'h0011_2233, 4'b0100, 0, "wr_byte2", rd); idle(1);
    req(BASE + 32'd10, 32'h0, 4'h0, 0, "rd_byte2", rd);        idle(1);
    checks++;
    if (rd !== 32'hCA11_F00D) begin errors++; $display("FAIL partial_strobe: got %h want %h", rd, 32'hCA11_F00D); end
  endtask

  task automatic test_boundary();
    logic [31:0] rd;
    req(BASE + 4 * WORDS, 32'h0, 4'h0, 0, "oor_top", rd);          idle(1);
    req(BASE + 4 * WORDS - 4, 32'h0, 4'h0, 0, "top_word_rd", rd);   idle(1);
    req(BASE + 4 * WORDS - 4, 32'h1234_5678, 4'hF, 0, "top_word_wr", rd); idle(1);
    req(BASE - 32'd4, 32'h5555_5555, 4'hF, 0, "oor_below", rd);     idle(1);
    req(BASE, 32'h0, 4'h0, 0, "bottom_word", rd);                  idle(1);
  endtask

  // Reset asserted in ISSUE (phase 1) or RWAIT (phase 2) of a read.
  task automatic test_reset_mid(input int phase);
    logic [31:0] rd;
    mem_valid = 1'b1; mem_addr = BASE + 32'd20; mem_wstrb = 4'h0; mem_wdata = '0;
    idle(phase);
    reset = 1'b1;
    #1;
    checks++;
    if (ram_ena !== 1'b0 || mem_ready !== 1'b0) begin
      errors++; $display("FAIL reset_mid%0d: got ena=%b rdy=%b want 0/0", phase, ram_ena, mem_ready);
    end
    mem_valid = 1'b0;
    n_rd = 0; n_wr = 0; n_err = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_mid%0d hold: got rdy=%b want 0", phase, mem_ready); end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);
    req(BASE + 32'd20, 32'h0, 4'h0, 0, "after_reset", rd); idle(1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    req(BASE + 32'd40, 32'hA5A5_0001, 4'hF, 0, "b2b_wr", rd);
    req(BASE + 32'd40, 32'h0, 4'h0, 1, "b2b_rd", rd);
    req(BASE + 4 * WORDS + 32'd64, 32'h0, 4'h0, 1, "b2b_oor", rd);
    req(BASE + 32'd44, 32'hFFFF_0000, 4'b0011, 1, "b2b_wr2", rd);
    idle(2);
  endtask

  task automatic test_random(input int n);
    logic [31:0] rd, a;
    logic [3:0]  ws;
    int gap, sel;
    gap = 1;
    for (int i = 0; i < n; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 7) a = BASE + 4 * $urandom_range(0, WORDS - 1) + 32'($urandom_range(0, 3));
      else if (sel == 7) a = BASE - 32'($urandom_range(1, 64));
      else if (sel == 8) a = BASE + 4 * WORDS + 32'($urandom_range(0, 64));
      else a = $urandom;
      ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      req(a, $urandom, ws, (gap == 0) ? 1 : 0, "random", rd);
      gap = int'($urandom_range(0, 2));
      idle(gap);
    end
    idle(1);
  endtask

`ifdef OPENSTRIVE_MEMCTRL_STATS_EN
  task automatic test_stats();
    logic [31:0] rd;
    reset = 1'b1; idle(1); reset = 1'b0; idle(1);
    n_rd = 0; n_wr = 0; n_err = 0;
    for (int i = 0; i < 3; i++) begin req(BASE + 32'(4 * i), $urandom, 4'hF, 0, "st_wr", rd); idle(1); end
    for (int i = 0; i < 2; i++) begin req(BASE + 32'(4 * i), 32'h0, 4'h0, 0, "st_rd", rd); idle(1); end
    req(BASE - 32'd4, 32'h0, 4'h0, 0, "st_err", rd); idle(1);
    checks++;
    if (wr_count !== 16'd3 || rd_count !== 16'd2 || err_count !== 8'd1) begin
      errors++; $display("FAIL stats: got wr=%0d rd=%0d err=%0d want 3/2/1", wr_count, rd_count, err_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_plan_sequence();
    test_boundary();
    test_reset_mid(1);
    test_reset_mid(2);
    test_back_to_back();
    test_random(60);
`ifdef OPENSTRIVE_MEMCTRL_STATS_EN
    checks++;
    if (32'(wr_count) !== 32'(n_wr) || 32'(rd_count) !== 32'(n_rd) || 32'(err_count) !== 32'(n_err)) begin
      errors++; $display("FAIL stats_model: got wr=%0d rd=%0d err=%0d want %0d/%0d/%0d",
                         wr_count, rd_count, err_count, n_wr, n_rd, n_err);
    end
    test_stats();
`endif
    idle(2);
    checks++;
    if (ready_pulses !== n_done || ready_double !== 0) begin
      errors++; $display("FAIL ready_pulses: got %0d (double %0d) want %0d (double 0)", ready_pulses, ready_double, n_done);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
